// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived line/frame totals, FSM state type and the
// colour-bar lookup used by the optional test pattern (VGA_TIMING_TEST_PATTERN_EN).
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'hFFFFFF;
            3'd1:    rgb = 24'hFFFF00;
            3'd2:    rgb = 24'h00FFFF;
            3'd3:    rgb = 24'h00FF00;
            3'd4:    rgb = 24'hFF00FF;
            3'd5:    rgb = 24'hFF0000;
            3'd6:    rgb = 24'h0000FF;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_hv_counter.sv
// Horizontal/vertical raster counters with combinational active and sync decode.
// Counters sit at zero whenever en is low so a restart always begins at h=0, v=0.
module vga_hv_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           active,
    output logic           hs_raw,
    output logic           vs_raw
);

    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_LAST = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Sync flags are active-high here; the top inverts them for the connector.
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: streams RGB888 pixels to the DAC with registered sync/blank.
// Define VGA_TIMING_TEST_PATTERN_EN to replace the stream with eight vertical colour bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pll_locked,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr,
    output state_e      dbg_state
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    state_e         state;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           active;
    logic           hs_raw;
    logic           vs_raw;
    logic           run;
    logic           under_set;
    logic [23:0]    pixel_rgb;

    // Counters advance only while RUN and the PLL is still locked this cycle.
    assign run = (state == ST_RUN) && pll_locked;

    vga_hv_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_hv (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .active  (active),
        .hs_raw  (hs_raw),
        .vs_raw  (vs_raw)
    );

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;
    logic       unused_stream;

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt >= H_W'(i * BAR_W)) bar_idx = 3'(i);
        end
    end

    assign pixel_rgb     = bar_colour(bar_idx);
    assign pix_ready     = 1'b0;
    assign under_set     = 1'b0;
    assign unused_stream = ^{pix_data, pix_valid};
`else
    // A pixel transfers on any cycle with pix_valid && pix_ready; pix_ready does not
    // wait for pix_valid, and a ready cycle without valid data is shown black.
    assign pix_ready = (state == ST_RUN) && active;
    assign pixel_rgb = pix_valid ? pix_data : 24'h0;
    assign under_set = pix_ready && !pix_valid;
`endif

    assign vga_sync_n = 1'b0;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            vga_r       <= 8'h0;
            vga_g       <= 8'h0;
            vga_b       <= 8'h0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (pll_locked)  state <= ST_RUN;
                ST_RUN:  if (!pll_locked) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (run) begin
                {vga_r, vga_g, vga_b} <= active ? pixel_rgb : 24'h0;
                vga_hs      <= ~hs_raw;
                vga_vs      <= ~vs_raw;
                vga_blank_n <= active;
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
            end else begin
                {vga_r, vga_g, vga_b} <= 24'h0;
                vga_hs      <= 1'b1;
                vga_vs      <= 1'b1;
                vga_blank_n <= 1'b0;
                frame_start <= 1'b0;
            end

            // A fresh underflow beats a simultaneous clear.
            if (under_set)          underflow <= 1'b1;
            else if (underflow_clr) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: reduced vertical timing, reference model indexed by pixel time.
// Also builds with VGA_TIMING_TEST_PATTERN_EN to check the colour-bar mode.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int HA = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VA = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam logic [29:0] RESET_VEC = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam logic UF_EXP = 1'b0;
`else
    localparam logic UF_EXP = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        pll_locked = 1'b0;
    logic [23:0] pix_data = 24'h0;
    logic        pix_valid = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        pix_ready;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic        frame_start, underflow;
    state_e      dbg_state;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .vga_hs        (vga_hs),
        .vga_vs        (vga_vs),
        .vga_blank_n   (vga_blank_n),
        .vga_sync_n    (vga_sync_n),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .dbg_state     (dbg_state)
    );

    // Clock and counters
    always #20 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int run_start = 0;

    // Reference model: m_t is the index of the next pixel since RUN began
    bit          m_run = 1'b0;
    int          m_t = 0;
    bit          m_uf = 1'b0;
    logic [29:0] exp_q[$];
    int          hs_falls[$];
    int          vs_falls[$];
    logic        prev_hs = 1'b1;
    logic        prev_vs = 1'b1;
    bit          ramp_mode = 1'b1;
    bit          rand_valid = 1'b0;
    bit          rand_clr = 1'b0;

    function automatic int pos_h();
        return m_t % HT;
    endfunction

    function automatic int pos_v();
        return (m_t / HT) % VT;
    endfunction

    function automatic logic [23:0] bar_rgb(input int h);
        case (h / (HA / 8))
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic pix_wanted();
`ifdef VGA_TIMING_TEST_PATTERN_EN
        return 1'b0;
`else
        return m_run && (pos_h() < HA) && (pos_v() < VA);
`endif
    endfunction

    task automatic model_edge();
        int          h, v;
        logic        act;
        logic [23:0] rgb;
        logic [29:0] e;
        h   = pos_h();
        v   = pos_v();
        act = (h < HA) && (v < VA);
        if (!reset_n) begin
            m_run = 1'b0;
            m_t   = 0;
            m_uf  = 1'b0;
            e     = RESET_VEC;
        end else begin
            if (pix_wanted() && !pix_valid) m_uf = 1'b1;
            else if (underflow_clr)         m_uf = 1'b0;
            if (m_run && pll_locked) begin
`ifdef VGA_TIMING_TEST_PATTERN_EN
                rgb = act ? bar_rgb(h) : 24'h0;
`else
                rgb = (act && pix_valid) ? pix_data : 24'h0;
`endif
                e = {rgb, !(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
                     act, 1'b0, (h == 0 && v == 0), m_uf};
                m_t++;
            end else begin
                e   = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_uf};
                m_t = 0;
            end
            m_run = pll_locked;
        end
        exp_q.push_back(e);
    endtask

    // Scoreboard check helpers
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start,
                 underflow, pix_ready, dbg_state} === {RESET_VEC, 1'b0, ST_IDLE}) else begin
            failures++;
            $error("FAIL %s observed=%h ready=%b state=%0d expected=%h ready=0 state=0", tag,
                   {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start,
                    underflow}, pix_ready, dbg_state, RESET_VEC);
        end
    endtask

    task automatic tick();
        logic [29:0] obs, e;
        logic [1:0]  ctl_obs, ctl_exp;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        obs = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, underflow};
        e   = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL outputs cyc=%0d observed=%h expected=%h", cyc, obs, e);
        end
        ctl_obs = {pix_ready, dbg_state};
        ctl_exp = {pix_wanted(), m_run};
        checks++;
        assert (ctl_obs === ctl_exp) else begin
            failures++;
            $error("FAIL ready_state cyc=%0d observed=%b expected=%b", cyc, ctl_obs, ctl_exp);
        end
        if (prev_hs && !vga_hs) hs_falls.push_back(cyc);
        if (prev_vs && !vga_vs) vs_falls.push_back(cyc);
        prev_hs = vga_hs;
        prev_vs = vga_vs;
    endtask

    // Driver tasks
    task automatic cycle();
        pix_data      = ramp_mode ? {8'(pos_v()), 16'(pos_h())} : 24'($urandom);
        pix_valid     = rand_valid ? ($urandom_range(0, 15) != 0) : 1'b1;
        underflow_clr = rand_clr ? ($urandom_range(0, 63) == 0) : 1'b0;
        tick();
    endtask

    task automatic run_until(input string tag, input int h, input int v, input int limit);
        int n;
        n = 0;
        while (!(m_run && pos_h() == h && pos_v() == v) && n < limit) begin
            cycle();
            n++;
        end
        check_val({tag, "_reach"}, 32'(n < limit), 32'd1);
    endtask

    task automatic wait_frame_start(input string tag);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!frame_start && n < 8);
        check_val(tag, n, 2);
        cycle();
        check_val({tag, "_width"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        #5 reset_n = 1'b0;
        #1 check_reset("reset_init");
        repeat (3) tick();

        // Release reset with the PLL already locked
        reset_n    = 1'b1;
        pll_locked = 1'b1;
        pix_valid  = 1'b1;
        tick();
        run_start = cyc;

`ifdef VGA_TIMING_TEST_PATTERN_EN
        run_until("bar_h85", 85, 0, HT);
        cycle();
        check_val("bar_h85_rgb", {vga_r, vga_g, vga_b}, 24'hFFFF00);
`else
        run_until("ramp_h639", 639, 0, HT);
        cycle();
        check_val("ramp_h639_rgb", {vga_r, vga_g, vga_b}, 24'd639);
        check_val("ramp_h639_blank_n", 32'(vga_blank_n), 32'd1);
        cycle();
        check_val("h640_blank", {vga_blank_n, vga_r, vga_g, vga_b}, 32'd0);
`endif

        // Underflow: one missing pixel at h=100, v=10
        ramp_mode     = 1'b0;
        pix_valid     = 1'b1;
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check_val("uf_precleared", 32'(underflow), 32'd0);
        run_until("uf_pos", 100, 10, HT * VT);
        pix_valid = 1'b0;
        pix_data  = 24'($urandom) | 24'h1;
        tick();
        check_val("uf_black", {vga_blank_n, vga_r, vga_g, vga_b}, {8'h1, 24'h0});
        check_val("uf_set", 32'(underflow), 32'(UF_EXP));
        pix_valid     = 1'b1;
        underflow_clr = 1'b1;
        tick();
        check_val("uf_clr", 32'(underflow), 32'd0);
        pix_valid = 1'b0;
        tick();
        check_val("uf_set_wins", 32'(underflow), 32'(UF_EXP));
        pix_valid = 1'b1;
        tick();
        underflow_clr = 1'b0;

        // Sync edge timing across two frames
        begin
            int n;
            n = 0;
            while (vs_falls.size() < 2 && n < 2 * HT * VT) begin
                cycle();
                n++;
            end
            check_val("vs_falls_reach", 32'(n < 2 * HT * VT), 32'd1);
        end
        check_val("first_hs_fall", hs_falls[0] - run_start, HA + HF + 1);
        check_val("line_period", hs_falls[1] - hs_falls[0], HT);
        check_val("frame_period", vs_falls[1] - vs_falls[0], HT * VT);

        // PLL lock lost mid-frame for five cycles
        run_until("pll_pos", 300, 5, HT * VT);
        pll_locked = 1'b0;
        repeat (5) cycle();
        check_val("pll_idle_out", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n},
                  {24'h0, 3'b110});
        check_val("pll_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        pll_locked = 1'b1;
        wait_frame_start("pll_restart");

        // Randomised stream, drops and clears
        rand_valid = 1'b1;
        rand_clr   = 1'b1;
        repeat (HT * VT / 2) cycle();
        rand_valid = 1'b0;
        rand_clr   = 1'b0;

        // Asynchronous reset in the middle of a line
        #7 reset_n = 1'b0;
        #1 check_reset("async_reset");
        exp_q.delete();
        m_run = 1'b0;
        m_t   = 0;
        m_uf  = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        wait_frame_start("reset_restart");
        repeat (HT) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal porch and sync widths in pixel clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, meaning vertical porch and sync widths in lines.
REQ-005 SHALL have port clk, input, 1 bit: the 25.175 MHz pixel clock from the VGA PLL outclk_0.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock indication, already synchronised to clk.
REQ-008 SHALL have ports pix_data, input, 24 bits, and pix_valid, input, 1 bit: upstream RGB888 pixel stream.
REQ-009 SHALL have port pix_ready, output, 1 bit: pixel request to upstream.
REQ-010 SHALL have ports vga_r, vga_g and vga_b, output, 8 bits each: DAC colour.
REQ-011 SHALL have ports vga_hs, vga_vs, vga_blank_n and vga_sync_n, output, 1 bit each: DAC and connector control.
REQ-012 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the first active pixel of a frame.
REQ-013 SHALL have ports underflow, output, 1 bit, sticky, and underflow_clr, input, 1 bit.

Function
REQ-014 SHALL have FSM states IDLE and RUN; IDLE -> RUN when pll_locked=1; RUN -> IDLE on the same cycle pll_locked=0.
REQ-015 SHALL have h_cnt count 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); it wraps to 0 and increments v_cnt on wrap.
REQ-016 SHALL have v_cnt count 0..V_TOTAL-1 (525) and wrap to 0 after the last line.
REQ-017 SHALL hold both counters at 0 in IDLE, so the first RUN cycle is h=0, v=0.
REQ-018 SHALL size the counters by $clog2 of their totals and use no arithmetic overflow beyond the wrap.
REQ-019 SHALL assert pix_ready combinationally iff state=RUN, h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-020 SHALL accept a pixel on a cycle where pix_valid and pix_ready are both 1; pix_valid without pix_ready SHALL be ignored.
REQ-021 SHALL drive vga_r/g/b one cycle after acceptance, equal to pix_data[23:16], [15:8] and [7:0].
REQ-022 SHALL, on a cycle where pix_ready=1 and pix_valid=0, output black one cycle later and set underflow.
REQ-023 SHALL clear underflow with underflow_clr; if clear and a new underflow occur in the same cycle, set wins.
REQ-024 SHALL register vga_hs, vga_vs and vga_blank_n with the same one-cycle latency as the colour outputs.
REQ-025 SHALL drive vga_hs low while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-026 SHALL drive vga_vs low over the equivalent vertical interval.
REQ-027 SHALL drive vga_blank_n high only for active pixels and force colour outputs to 0 when it is low.
REQ-028 SHALL tie vga_sync_n to 0.
REQ-029 SHALL pulse frame_start, registered, in the cycle the pixel at h=0, v=0 is presented on the outputs.
REQ-030 SHALL, in IDLE, drive colour 0, vga_hs=1, vga_vs=1, vga_blank_n=0 and pix_ready=0.

Reset
REQ-031 SHALL, on reset_n=0, go to IDLE, zero counters, drive colour 0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0 and underflow=0.
REQ-032 SHALL, on reset mid-frame, abandon the frame and restart at h=0, v=0 after release once pll_locked=1.

Configuration
REQ-033 SHALL, with VGA_TIMING_TEST_PATTERN_EN defined, replace pix_data with 8 vertical colour bars of 80 pixels each (white, yellow, cyan, green, magenta, red, blue, black).
REQ-034 SHALL, with VGA_TIMING_TEST_PATTERN_EN defined, hold pix_ready at 0 and never set underflow.
REQ-035 SHALL, with VGA_TIMING_TEST_PATTERN_EN undefined, contain no pattern logic and use the streaming behaviour above.

Structure
REQ-036 SHALL place the default timing constants, the H_TOTAL/V_TOTAL derivations and the FSM state enum in package vga_timing_pkg.
REQ-037 SHALL implement the h/v counter pair as sub-module vga_hv_counter, which emits counts, active, hs_raw and vs_raw.

Verification
REQ-038 SHALL verify: reset release with pll_locked=1 -> first vga_hs falling edge 657 cycles later, line period 800 cycles, frame period 420000 cycles.
REQ-039 SHALL verify: pix_valid=1 always with ramp data -> pixel at h=639 equals value 639 and at h=640 vga_blank_n=0 with colour 0.
REQ-040 SHALL verify: pix_valid=0 for 1 cycle at h=100, v=10 -> black pixel and underflow=1; underflow_clr -> underflow=0.
REQ-041 SHALL verify: pll_locked dropped at h=300, v=200 for 5 cycles -> outputs idle, then restart at h=0, v=0 with frame_start.
REQ-042 SHALL verify: reset_n asserted mid-line -> all outputs at reset values asynchronously, before the next clk edge.
REQ-043 SHALL verify: VGA_TIMING_TEST_PATTERN_EN defined -> pixel at h=85 equals 0xFFFF00, pix_ready=0 throughout.
